// File: rtl/ddram_responder.sv
// ddram_responder
//   Responder end of the DDRAM burst port, backed by on-chip block RAM.
//   Serves reads with a fixed latency and back-to-back beats. Accepts write
//   bursts with optional gaps. Raises a sticky error flag on protocol misuse
//   and on accesses outside the address window.
//
//   Optional feature: define DDRAM_BUSY_INJECT_EN to add pseudo-random BUSY
//   stalls in IDLE/WR_BURST, driven by a 16-bit LFSR.
//
// Ports
//   DDRAM_CLK         sole clock
//   reset             synchronous, active-high; RAM contents are retained
//   DDRAM_BUSY        1 = command/beat not accepted this cycle
//   DDRAM_BURSTCNT    beats in burst (0 is treated as 1), sampled on first beat
//   DDRAM_ADDR        64-bit word address, sampled on first beat
//   DDRAM_RD          read request
//   DDRAM_WE          write beat
//   DDRAM_DIN/BE      write data / byte enables
//   DDRAM_DOUT        read data (holds the last beat when DOUT_READY=0)
//   DDRAM_DOUT_READY  read beat valid
//   err               sticky protocol/window error, cleared only by reset
module ddram_responder #(
   parameter int          ADDR_W     = 12,
   parameter int          RD_LATENCY = 4,
   parameter logic [3:0]  BASE       = 4'h3
) (
   input  logic        DDRAM_CLK,
   input  logic        reset,
   output logic        DDRAM_BUSY,
   input  logic [7:0]  DDRAM_BURSTCNT,
   input  logic [28:0] DDRAM_ADDR,
   input  logic        DDRAM_RD,
   input  logic        DDRAM_WE,
   input  logic [63:0] DDRAM_DIN,
   input  logic [7:0]  DDRAM_BE,
   output logic [63:0] DDRAM_DOUT,
   output logic        DDRAM_DOUT_READY,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT, WR_BURST} state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;       // next RAM word of the current burst
   logic [7:0]        rem;       // beats still to transfer
   logic [7:0]        wcnt;      // remaining RD_WAIT cycles minus one
   logic              in_win;    // current burst targets the window
   logic              stall;

   logic [63:0] ram [0:(1<<ADDR_W)-1];

   // Address bits between the RAM index and the window field are don't-care.
   logic unused_addr;
   assign unused_addr = ^DDRAM_ADDR[24:ADDR_W];

`ifdef DDRAM_BUSY_INJECT_EN
   logic [15:0] lfsr;
   always_ff @(posedge DDRAM_CLK) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
   assign stall = (state == IDLE || state == WR_BURST) && (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // DOUT_READY keeps BUSY high through the final read beat, which is
   // issued while the state has already returned to IDLE.
   assign DDRAM_BUSY = (state == RD_WAIT) || (state == RD_BEAT) || DDRAM_DOUT_READY || stall;

   logic       win_now, acc_wr, acc_rd, wr_beat, ram_we;
   logic [7:0] n_beats;
   logic [ADDR_W-1:0] widx;

   assign win_now = (DDRAM_ADDR[28:25] == BASE);
   assign n_beats = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
   assign acc_wr  = (state == IDLE) && !DDRAM_BUSY && DDRAM_WE;
   assign acc_rd  = (state == IDLE) && !DDRAM_BUSY && DDRAM_RD && !DDRAM_WE;
   assign wr_beat = (state == WR_BURST) && !DDRAM_BUSY && DDRAM_WE;
   assign ram_we  = !reset && ((acc_wr && win_now) || (wr_beat && in_win));
   assign widx    = acc_wr ? DDRAM_ADDR[ADDR_W-1:0] : idx;

   // RAM has no reset; only byte-enabled lanes are written.
   always_ff @(posedge DDRAM_CLK) begin
      if (ram_we)
         for (int b = 0; b < 8; b++)
            if (DDRAM_BE[b]) ram[widx][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
   end

   always_ff @(posedge DDRAM_CLK) begin
      if (reset) begin
         state            <= IDLE;
         idx              <= '0;
         rem              <= 8'd0;
         wcnt             <= 8'd0;
         in_win           <= 1'b0;
         DDRAM_DOUT       <= 64'd0;
         DDRAM_DOUT_READY <= 1'b0;
         err              <= 1'b0;
      end else begin
         DDRAM_DOUT_READY <= 1'b0;
         case (state)
            IDLE: begin
               if (acc_wr) begin
                  // RD together with WE executes as a write, flagged.
                  if (DDRAM_BURSTCNT == 8'd0 || !win_now || DDRAM_RD) err <= 1'b1;
                  in_win <= win_now;
                  idx    <= DDRAM_ADDR[ADDR_W-1:0] + 1'b1;
                  rem    <= n_beats - 8'd1;
                  if (n_beats > 8'd1) state <= WR_BURST;
               end else if (acc_rd) begin
                  if (DDRAM_BURSTCNT == 8'd0 || !win_now) err <= 1'b1;
                  in_win <= win_now;
                  idx    <= DDRAM_ADDR[ADDR_W-1:0];
                  rem    <= n_beats;
                  // RD_WAIT spans RD_LATENCY-1 cycles; RD_BEAT issues the
                  // beat on the following edge.
                  if (RD_LATENCY > 1) begin
                     state <= RD_WAIT;
                     wcnt  <= 8'(RD_LATENCY - 2);
                  end else begin
                     state <= RD_BEAT;
                  end
               end
            end
            RD_WAIT: begin
               if (wcnt == 8'd0) state <= RD_BEAT;
               else              wcnt  <= wcnt - 8'd1;
            end
            RD_BEAT: begin
               DDRAM_DOUT_READY <= 1'b1;
               DDRAM_DOUT       <= in_win ? ram[idx] : 64'd0;
               idx              <= idx + 1'b1;
               rem              <= rem - 8'd1;
               if (rem == 8'd1) state <= IDLE;
            end
            WR_BURST: begin
               if (DDRAM_RD) err <= 1'b1;  // read is ignored mid-burst
               if (wr_beat) begin
                  idx <= idx + 1'b1;
                  rem <= rem - 8'd1;
                  if (rem == 8'd1) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddram_responder.sv
// tb_ddram_responder
//   Bench for ddram_responder. A word-array memory model built from the
//   access rules (window check, byte masks, modulo index wrap) predicts all
//   read data. A table covers single-word cases. Hand sequences cover wrap,
//   window, reset-abort and error cases. A randomized phase mixes write
//   bursts (with gaps) and read bursts.
module tb_ddram_responder;
   localparam int L  = 4;
   localparam int AW = 12;

   logic        DDRAM_CLK = 1'b0;
   logic        reset;
   logic        DDRAM_BUSY;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic        DDRAM_RD, DDRAM_WE;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic [63:0] DDRAM_DOUT;
   logic        DDRAM_DOUT_READY;
   logic        err;

   ddram_responder #(.ADDR_W(AW), .RD_LATENCY(L), .BASE(4'h3)) dut (
      .DDRAM_CLK(DDRAM_CLK), .reset(reset), .DDRAM_BUSY(DDRAM_BUSY),
      .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
      .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN),
      .DDRAM_BE(DDRAM_BE), .DDRAM_DOUT(DDRAM_DOUT),
      .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .err(err));

   always #5 DDRAM_CLK = ~DDRAM_CLK;

   int checks = 0;
   int failures = 0;

   logic [63:0] mem   [0:(1<<AW)-1];
   bit          known [0:(1<<AW)-1];
   logic [63:0] wq[$];
   logic [7:0]  bq[$];
   logic [63:0] gotq[$];

   typedef struct {
      bit          is_wr;
      logic [28:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge DDRAM_CLK);
      #1;
   endtask

   task automatic wait_free();
      int n = 0;
      while (DDRAM_BUSY && n < 200) begin tick(); n++; end
      if (DDRAM_BUSY) chk("busy_timeout", 64'(DDRAM_BUSY), 64'd0);
   endtask

   function automatic bit in_window(input logic [28:0] a);
      return a[28:25] == 4'h3;
   endfunction

   function automatic int widx(input logic [28:0] a, input int i);
      return (int'(a[AW-1:0]) + i) % (1 << AW);
   endfunction

   function automatic void mwrite(input logic [28:0] a, input int i,
                                  input logic [63:0] d, input logic [7:0] be);
      int k;
      if (!in_window(a)) return;
      k = widx(a, i);
      for (int b = 0; b < 8; b++)
         if (be[b]) mem[k][8*b +: 8] = d[8*b +: 8];
      if (be == 8'hFF) known[k] = 1'b1;
   endfunction

   // Holds WE with the same data until a cycle with BUSY=0 takes it.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] be);
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 200) begin
         DDRAM_WE = 1'b1; DDRAM_DIN = d; DDRAM_BE = be;
         acc = !DDRAM_BUSY;
         tick();
         n++;
      end
      DDRAM_WE = 1'b0;
      if (!acc) chk("beat_timeout", 64'(acc), 64'd1);
   endtask

   // Writes n beats from wq/bq; optionally inserts idle gaps between beats.
   task automatic wr(input logic [28:0] a, input logic [7:0] bc, input int n, input bit gaps);
      DDRAM_ADDR = a; DDRAM_BURSTCNT = bc;
      for (int b = 0; b < n; b++) begin
         if (b > 0 && gaps && $urandom_range(0, 3) == 0) begin
            DDRAM_WE = 1'b0; tick();
         end
         send_beat(wq[b], bq[b]);
         mwrite(a, b, wq[b], bq[b]);
      end
   endtask

   task automatic wr1(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
      wq.delete(); bq.delete();
      wq.push_back(d); bq.push_back(be);
      wr(a, 8'd1, 1, 1'b0);
   endtask

   // Issues a read, checks latency and back-to-back beats, collects data.
   task automatic rd(input logic [28:0] a, input logic [7:0] bc, input int n, input string nm);
      int lat;
      gotq.delete();
      wait_free();
      DDRAM_ADDR = a; DDRAM_BURSTCNT = bc; DDRAM_RD = 1'b1;
      tick();
      DDRAM_RD = 1'b0;
      chk({nm, "_busy_after_accept"}, 64'(DDRAM_BUSY), 64'd1);
      lat = 0;
      while (!DDRAM_DOUT_READY && lat < 64) begin tick(); lat++; end
      chk({nm, "_latency"}, 64'(lat), 64'(L));
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            tick();
            chk({nm, "_beat_valid"}, 64'(DDRAM_DOUT_READY), 64'd1);
         end
         gotq.push_back(DDRAM_DOUT);
      end
      tick();
      chk({nm, "_ready_drop"}, 64'(DDRAM_DOUT_READY), 64'd0);
      chk({nm, "_dout_hold"}, DDRAM_DOUT, gotq[n-1]);
`ifndef DDRAM_BUSY_INJECT_EN
      chk({nm, "_busy_release"}, 64'(DDRAM_BUSY), 64'd0);
`endif
   endtask

   // Read compared against the memory model.
   task automatic rdc(input logic [28:0] a, input int n, input string nm);
      int k;
      rd(a, 8'(n), n, nm);
      for (int i = 0; i < n; i++) begin
         k = widx(a, i);
         if (!in_window(a))  chk({nm, "_data_oow"}, gotq[i], 64'd0);
         else if (known[k])  chk({nm, "_data"}, gotq[i], mem[k]);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [28:0] a;
      int n;

      reset = 1'b1; DDRAM_RD = 0; DDRAM_WE = 0; DDRAM_ADDR = '0;
      DDRAM_BURSTCNT = 8'd1; DDRAM_DIN = '0; DDRAM_BE = '0;
      for (int i = 0; i < (1 << AW); i++) known[i] = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("reset_busy",  64'(DDRAM_BUSY), 64'd0);
      chk("reset_ready", 64'(DDRAM_DOUT_READY), 64'd0);
      chk("reset_dout",  DDRAM_DOUT, 64'd0);
      chk("reset_err",   64'(err), 64'd0);

      // Single-word table; read expectations are hand-derived constants.
      tbl[0] = '{1'b1, 29'h06000010, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
      tbl[1] = '{1'b0, 29'h06000010, 64'h0, 8'h00, 64'h0123456789ABCDEF};
      tbl[2] = '{1'b1, 29'h06000020, 64'h0, 8'hFF, 64'h0};
      tbl[3] = '{1'b1, 29'h06000020, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 64'h0};
      tbl[4] = '{1'b0, 29'h06000020, 64'h0, 8'h00, 64'h00000000_FFFFFFFF};
      tbl[5] = '{1'b1, 29'h06000021, 64'h11111111_11111111, 8'hFF, 64'h0};
      tbl[6] = '{1'b1, 29'h06000021, 64'hAABBCCDD_EEFF0011, 8'hF0, 64'h0};
      tbl[7] = '{1'b0, 29'h06000021, 64'h0, 8'h00, 64'hAABBCCDD_11111111};
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].is_wr) wr1(tbl[i].addr, tbl[i].data, tbl[i].be);
         else begin
            rd(tbl[i].addr, 8'd1, 1, "tbl_rd");
            chk($sformatf("tbl_data_%0d", i), gotq[0], tbl[i].exp);
         end
      end
      chk("tbl_err_clear", 64'(err), 64'd0);

      // Burst-2 wrap at the top of RAM.
      wq.delete(); bq.delete();
      wq.push_back(64'hCAFE0000_00000FFF); bq.push_back(8'hFF);
      wq.push_back(64'hCAFE0000_00000000); bq.push_back(8'hFF);
      wr(29'h06000FFF, 8'd2, 2, 1'b0);
      rd(29'h06000FFF, 8'd2, 2, "wrap");
      chk("wrap_beat0", gotq[0], 64'hCAFE0000_00000FFF);
      chk("wrap_beat1", gotq[1], 64'hCAFE0000_00000000);

      // Preload random region 0x40..0x7F with a 64-beat burst with gaps.
      wq.delete(); bq.delete();
      for (int i = 0; i < 64; i++) begin
         wq.push_back({$urandom, $urandom}); bq.push_back(8'hFF);
      end
      wr(29'h06000040, 8'd64, 64, 1'b1);
      rdc(29'h06000040, 8, "pre8");

      // Randomized mix of write and read bursts.
      for (int t = 0; t < 40; t++) begin
         a = {4'h3, 13'd0, 12'(12'h040 + $urandom_range(0, 59))};
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 0) begin
            wq.delete(); bq.delete();
            for (int i = 0; i < n; i++) begin
               wq.push_back({$urandom, $urandom}); bq.push_back(8'($urandom));
            end
            wr(a, 8'(n), n, 1'b1);
         end else begin
            rdc(a, n, "rnd");
         end
      end
      chk("rnd_err_clear", 64'(err), 64'd0);

      // Out-of-window: zero data at normal latency, err; writes dropped.
      rd(29'h00000000, 8'd1, 1, "oow");
      chk("oow_data", gotq[0], 64'd0);
      chk("oow_err", 64'(err), 64'd1);
      wr1(29'h00000010, 64'hDEADDEAD_DEADDEAD, 8'hFF);
      rd(29'h06000010, 8'd1, 1, "oow_keep");
      chk("oow_keep_data", gotq[0], 64'h0123456789ABCDEF);

      // Reset one cycle after a burst-8 read is accepted.
      wait_free();
      DDRAM_ADDR = 29'h06000040; DDRAM_BURSTCNT = 8'd8; DDRAM_RD = 1'b1;
      tick();
      DDRAM_RD = 1'b0;
      do_reset();
      chk("abort_busy", 64'(DDRAM_BUSY), 64'd0);
      chk("abort_err", 64'(err), 64'd0);
      chk("abort_dout", DDRAM_DOUT, 64'd0);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (DDRAM_DOUT_READY) cnt++;
         tick();
      end
      chk("abort_no_beats", 64'(cnt), 64'd0);

      // BURSTCNT=0 acts as a single beat and flags err.
      wq.delete(); bq.delete();
      wq.push_back(64'h55555555_55555555); bq.push_back(8'hFF);
      wr(29'h06000090, 8'd0, 1, 1'b0);
      chk("bc0_err", 64'(err), 64'd1);
      rd(29'h06000090, 8'd1, 1, "bc0");
      chk("bc0_data", gotq[0], 64'h55555555_55555555);

      // RD and WE together in IDLE: write executes, err set.
      do_reset();
      chk("rdwe_err_pre", 64'(err), 64'd0);
      wait_free();
      DDRAM_ADDR = 29'h06000091; DDRAM_BURSTCNT = 8'd1; DDRAM_RD = 1'b1;
      DDRAM_WE = 1'b1; DDRAM_DIN = 64'h66666666_66666666; DDRAM_BE = 8'hFF;
      tick();
      DDRAM_RD = 1'b0; DDRAM_WE = 1'b0;
      mwrite(29'h06000091, 0, 64'h66666666_66666666, 8'hFF);
      chk("rdwe_err", 64'(err), 64'd1);
      chk("rdwe_no_read", 64'(DDRAM_DOUT_READY), 64'd0);
      rd(29'h06000091, 8'd1, 1, "rdwe");
      chk("rdwe_data", gotq[0], 64'h66666666_66666666);

      // RD inside a write burst is ignored and flags err.
      do_reset();
      DDRAM_ADDR = 29'h06000092; DDRAM_BURSTCNT = 8'd2;
      wait_free();
      send_beat(64'h77777777_77777777, 8'hFF);
      DDRAM_RD = 1'b1; tick(); DDRAM_RD = 1'b0;
      chk("wrrd_err", 64'(err), 64'd1);
      cnt = 0;
      for (int i = 0; i < L + 2; i++) begin
         if (DDRAM_DOUT_READY) cnt++;
         tick();
      end
      chk("wrrd_ignored", 64'(cnt), 64'd0);
      send_beat(64'h88888888_88888888, 8'hFF);
      rd(29'h06000092, 8'd2, 2, "wrrd");
      chk("wrrd_beat0", gotq[0], 64'h77777777_77777777);
      chk("wrrd_beat1", gotq[1], 64'h88888888_88888888);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
